// File: rtl/pe_result_collector.sv
// Collects one result per PE and streams the frame out in PE order.
// Optional macro DOUT_LAST_EN adds a dout_last end-of-frame marker.
module pe_result_collector #(
    parameter int PE_NUM     = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [PE_NUM-1:0]              pe_out_v,
    input  logic [PE_NUM*DATA_WIDTH*2-1:0] pe_out,
    input  logic                           dout_ready,
    output logic                           dout_overlay_v,
    output logic [DATA_WIDTH*2-1:0]        dout_overlay,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           overflow
`ifdef DOUT_LAST_EN
    ,
    output logic                           dout_last
`endif
);

    localparam int WW = DATA_WIDTH * 2;
    localparam int IW = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam logic [IW-1:0] LAST = IW'(PE_NUM - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    logic [PE_NUM-1:0] got;
    logic [WW-1:0]     slot_buf [PE_NUM];
    logic [IW-1:0]     idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            got        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            for (int i = 0; i < PE_NUM; i++) begin
                slot_buf[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // First result per slot wins; repeats are flagged.
                    for (int i = 0; i < PE_NUM; i++) begin
                        if (pe_out_v[i]) begin
                            if (!got[i]) begin
                                slot_buf[i] <= pe_out[i*WW +: WW];
                                got[i]      <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                    if ((&got) || load) begin
                        state <= SEND;
                        idx   <= '0;
                    end
                end
                SEND: begin
                    if (|pe_out_v) begin
                        overflow <= 1'b1;
                    end
                    if (dout_ready) begin
                        if (idx == LAST) begin
                            state      <= IDLE;
                            got        <= '0;
                            idx        <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slots never captured this frame read as zero, hiding stale data.
    assign dout_overlay_v = (state == SEND);
    assign busy           = (state == SEND);
    assign dout_overlay   = (state == SEND && got[idx]) ? slot_buf[idx] : '0;

`ifdef DOUT_LAST_EN
    assign dout_last = dout_overlay_v && (idx == LAST);
`endif

endmodule

// File: tb/tb_pe_result_collector.sv
// Bench for pe_result_collector: vector table, corner sequences,
// and randomized frames against a first-result-wins frame model.
module tb_pe_result_collector;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int W  = DW * 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           load;
    logic [N-1:0]   pe_out_v;
    logic [N*W-1:0] pe_out;
    logic           dout_ready;
    logic           dout_overlay_v;
    logic [W-1:0]   dout_overlay;
    logic           busy;
    logic           frame_done;
    logic           overflow;
`ifdef DOUT_LAST_EN
    logic           dout_last;
`endif

    pe_result_collector #(.PE_NUM(N), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .pe_out_v       (pe_out_v),
        .pe_out         (pe_out),
        .dout_ready     (dout_ready),
        .dout_overlay_v (dout_overlay_v),
        .dout_overlay   (dout_overlay),
        .busy           (busy),
        .frame_done     (frame_done),
        .overflow       (overflow)
`ifdef DOUT_LAST_EN
        ,
        .dout_last      (dout_last)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    logic [W-1:0] rx_q [$];
    logic         rx_last_q [$];
    int           fd_cnt = 0;
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_word = '0;

    always @(posedge clk) begin
        if (!rst) begin
            if (prev_hold && dout_overlay_v)
                check("hold_stable", dout_overlay, prev_word);
            if (dout_overlay_v && dout_ready) begin
                rx_q.push_back(dout_overlay);
`ifdef DOUT_LAST_EN
                rx_last_q.push_back(dout_last);
`endif
            end
            if (frame_done)
                fd_cnt <= fd_cnt + 1;
        end
        prev_hold <= dout_overlay_v && !dout_ready && !rst;
        prev_word <= dout_overlay;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        pe_out_v = '0;
        load     = 1'b0;
    endtask

    task automatic send_full(logic [W-1:0] base);
        for (int k = 0; k < N; k++) begin
            pe_out_v = N'(1) << k;
            pe_out   = '0;
            pe_out[k*W +: W] = base + W'(k);
            tick();
        end
        clear_in();
    endtask

    task automatic wait_frame(string name, int target, int mode);
        int k;
        k = 0;
        while (fd_cnt < target && k < 400) begin
            if (mode == 0)
                dout_ready = 1'b1;
            else if (mode == 1)
                dout_ready = (k % 3 == 0);
            else
                dout_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        dout_ready = 1'b1;
        n_chk++;
        if (fd_cnt < target) begin
            n_fail++;
            $display("FAIL %s_timeout: frame_done count %0d required %0d",
                     name, fd_cnt, target);
        end
    endtask

    task automatic check_frame(string name, logic [N*W-1:0] exp);
        logic [W-1:0] a;
        check({name, "_len"}, W'(rx_q.size()), W'(N));
        for (int i = 0; i < N; i++) begin
            a = (i < rx_q.size()) ? rx_q[i] : 32'hxxxxxxxx;
            check(name, a, exp[i*W +: W]);
`ifdef DOUT_LAST_EN
            if (i < rx_last_q.size())
                check({name, "_last"}, W'(rx_last_q[i]), W'(i == N - 1));
`endif
        end
        rx_q.delete();
        rx_last_q.delete();
    endtask

    function automatic logic [N*W-1:0] seq_frame(logic [W-1:0] base);
        logic [N*W-1:0] f;
        for (int i = 0; i < N; i++)
            f[i*W +: W] = base + W'(i);
        return f;
    endfunction

    typedef struct {
        logic [N-1:0]   mask;
        logic [N*W-1:0] data;
        logic [N*W-1:0] exp;
    } vec_t;

    vec_t           tbl [4];
    logic [N-1:0]   tmask [4];
    logic [N*W-1:0] e;
    logic [W-1:0]   v;
    logic [W-1:0]   first_val [N];
    logic           seen [N];
    int             order [N];
    int             cnt;
    int             pe;
    int             j;
    int             tmp;
    int             fd0;
    logic           exp_ov;
    logic           partial;

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        pe_out_v   = '0;
        pe_out     = '0;
        dout_ready = 1'b0;

        tmask[0] = 8'h21;
        tmask[1] = 8'hFF;
        tmask[2] = 8'h00;
        tmask[3] = 8'h80;
        for (int t = 0; t < 4; t++) begin
            tbl[t].mask = tmask[t];
            for (int i = 0; i < N; i++) begin
                v = {8'(t + 1), 24'(i * 32'h111)};
                tbl[t].data[i*W +: W] = tmask[t][i] ? v : 32'hDEAD0000 + W'(i);
                tbl[t].exp[i*W +: W]  = tmask[t][i] ? v : '0;
            end
        end
        tbl[0].data[0*W +: W] = 32'hAAAA5555;
        tbl[0].data[5*W +: W] = 32'h12345678;
        tbl[0].exp = {32'h0, 32'h0, 32'h12345678, 32'h0,
                      32'h0, 32'h0, 32'h0, 32'hAAAA5555};

        tick();
        tick();
        rst = 1'b0;
        check("rst_v", W'(dout_overlay_v), '0);
        check("rst_data", dout_overlay, '0);
        check("rst_busy", W'(busy), '0);
        check("rst_fd", W'(frame_done), '0);
        check("rst_ovf", W'(overflow), '0);
`ifdef DOUT_LAST_EN
        check("rst_last", W'(dout_last), '0);
`endif

        // Scenario 1: one PE per cycle, then latency and order.
        dout_ready = 1'b1;
        fd0 = fd_cnt;
        send_full(32'h10000000);
        check("lat_edge1_v", W'(dout_overlay_v), '0);
        tick();
        check("lat_edge2_v", W'(dout_overlay_v), 1);
        check("lat_edge2_busy", W'(busy), 1);
        check("lat_edge2_word", dout_overlay, 32'h10000000);
        wait_frame("s1", fd0 + 1, 0);
        check_frame("s1_word", seq_frame(32'h10000000));
        tick();
        tick();
        check("s1_fd_once", W'(fd_cnt), W'(fd0 + 1));
        check("s1_ovf", W'(overflow), '0);
        check("s1_idle", W'(busy), '0);

        // Scenario 2: back-pressure pattern 1,0,0.
        fd0 = fd_cnt;
        send_full(32'h10000000);
        wait_frame("s2", fd0 + 1, 1);
        check_frame("s2_word", seq_frame(32'h10000000));

        // Table: partial captures followed by a load pulse.
        for (int t = 0; t < 4; t++) begin
            fd0 = fd_cnt;
            pe_out_v = tbl[t].mask;
            pe_out   = tbl[t].data;
            tick();
            pe_out_v = '0;
            load     = 1'b1;
            tick();
            load = 1'b0;
            wait_frame("tbl", fd0 + 1, 0);
            check_frame("tbl_word", tbl[t].exp);
            tick();
            tick();
            check("tbl_single_frame", W'(fd_cnt), W'(fd0 + 1));
        end

        // Scenario 4: duplicate report, then input during SEND.
        fd0 = fd_cnt;
        pe_out_v = 8'h08;
        pe_out   = '0;
        pe_out[3*W +: W] = 32'h1;
        tick();
        pe_out[3*W +: W] = 32'h2;
        tick();
        check("s4_ovf", W'(overflow), 1);
        for (int k = 0; k < N; k++) begin
            if (k != 3) begin
                pe_out_v = N'(1) << k;
                pe_out   = '0;
                pe_out[k*W +: W] = 32'h40000000 + W'(k);
                tick();
            end
        end
        clear_in();
        for (int k = 0; k < 40 && !busy; k++)
            tick();
        check("s4_in_send", W'(busy), 1);
        pe_out_v = 8'h04;
        pe_out   = '0;
        pe_out[2*W +: W] = 32'hBAD0BAD0;
        tick();
        pe_out_v = '0;
        wait_frame("s4", fd0 + 1, 0);
        e = seq_frame(32'h40000000);
        e[3*W +: W] = 32'h1;
        check_frame("s4_word", e);
        fd0 = fd_cnt;
        pe_out_v = 8'h01;
        pe_out   = '0;
        pe_out[0*W +: W] = 32'h55;
        pe_out[2*W +: W] = 32'h77;
        tick();
        pe_out_v = '0;
        load     = 1'b1;
        tick();
        load = 1'b0;
        wait_frame("s4b", fd0 + 1, 0);
        e = '0;
        e[0*W +: W] = 32'h55;
        check_frame("s4b_word", e);

        // load held high: back-to-back all-zero frames.
        fd0 = fd_cnt;
        load = 1'b1;
        for (int k = 0; k < 100 && rx_q.size() < 2 * N; k++)
            tick();
        load = 1'b0;
        tick();
        tick();
        check("hold_load_frames", W'(fd_cnt), W'(fd0 + 2));
        check("hold_load_len", W'(rx_q.size()), W'(2 * N));
        for (int i = 0; i < rx_q.size(); i++)
            check("hold_load_word", rx_q[i], '0);
        check("hold_load_idle", W'(busy), '0);
        rx_q.delete();
        rx_last_q.delete();

        // Scenario 5: reset after third transfer.
        check("s5_ovf_pre", W'(overflow), 1);
        fd0 = fd_cnt;
        send_full(32'h60000000);
        for (int k = 0; k < 50 && rx_q.size() < 3; k++)
            tick();
        check("s5_three", W'(rx_q.size()), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s5_v", W'(dout_overlay_v), '0);
        check("s5_data", dout_overlay, '0);
        check("s5_busy", W'(busy), '0);
        check("s5_ovf", W'(overflow), '0);
        tick();
        tick();
        check("s5_no_fd", W'(fd_cnt), W'(fd0));
        rx_q.delete();
        rx_last_q.delete();
        fd0 = fd_cnt;
        send_full(32'h70000000);
        wait_frame("s5b", fd0 + 1, 0);
        check_frame("s5b_word", seq_frame(32'h70000000));

        // Randomized frames against the first-result-wins model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ov = 1'b0;
        for (int f = 0; f < 15; f++) begin
            fd0 = fd_cnt;
            for (int i = 0; i < N; i++) begin
                order[i]     = i;
                seen[i]      = 1'b0;
                first_val[i] = '0;
            end
            for (int i = N - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = order[i];
                order[i] = order[j];
                order[j] = tmp;
            end
            partial = ($urandom_range(0, 3) == 0);
            cnt = partial ? $urandom_range(0, N - 1) : N;
            for (int p = 0; p < cnt; p++) begin
                pe = order[p];
                v  = $urandom;
                pe_out   = {N{$urandom}};
                pe_out_v = N'(1) << pe;
                pe_out[pe*W +: W] = v;
                first_val[pe] = v;
                seen[pe] = 1'b1;
                tick();
                if ($urandom_range(0, 3) == 0) begin
                    pe_out[pe*W +: W] = ~v;
                    exp_ov = 1'b1;
                    tick();
                end
                pe_out_v = '0;
                for (int g = $urandom_range(0, 2); g > 0; g--)
                    tick();
            end
            if (partial) begin
                load = 1'b1;
                tick();
                load = 1'b0;
            end
            wait_frame("rnd", fd0 + 1, 2);
            for (int i = 0; i < N; i++)
                e[i*W +: W] = seen[i] ? first_val[i] : '0;
            check_frame("rnd_word", e);
            check("rnd_ovf", W'(overflow), W'(exp_ov));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
